// File: rtl/system_tick_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : system_tick_scheduler
//  Description : Avalon-MM master for the 16-bit-register interval timer.
//                Programs the timer period and starts it in continuous
//                mode with its IRQ enabled. Clears the timeout status on
//                every IRQ, and fans each acknowledged tick out to NUM_CH
//                periodic event channels built from down-counters.
//  Ports       : clk, reset          - clock, async active-high reset
//                enable              - 1 = configure/run timer, 0 = stop
//                ch_period_wr/ch_sel/ch_period_data - host period load
//                ch_event            - 1-cycle pulse per channel
//                tick_count          - acknowledged tick counter (wraps)
//                running             - FSM in RUN/ACK/SETTLE
//                timer_address/chipselect/write_n/writedata - timer bus
//                timer_irq           - level IRQ from timer
//  Revision    : 1.0 - initial release
// ============================================================================
module system_tick_scheduler #(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = 8,
    parameter logic [31:0] TICK_PERIOD = 32'h0002_1B0F
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      ch_period_wr,
    input  logic [$clog2(NUM_CH)-1:0] ch_sel,
    input  logic [CNT_W-1:0]          ch_period_data,
    output logic [NUM_CH-1:0]         ch_event,
    output logic [15:0]               tick_count,
    output logic                      running,
    output logic [2:0]                timer_address,
    output logic                      timer_chipselect,
    output logic                      timer_write_n,
    output logic [15:0]               timer_writedata,
    input  logic                      timer_irq
);

    localparam int          SEL_W        = $clog2(NUM_CH);
    localparam logic [2:0]  c_ADDR_STAT  = 3'd0;
    localparam logic [2:0]  c_ADDR_CTRL  = 3'd1;
    localparam logic [2:0]  c_ADDR_PL    = 3'd2;
    localparam logic [2:0]  c_ADDR_PH    = 3'd3;
    localparam logic [15:0] c_CTRL_START = 16'h0007;  // ITO | CONT | START
    localparam logic [15:0] c_CTRL_STOP  = 16'h0008;  // STOP

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_PL   = 3'd1,
        ST_WR_PH   = 3'd2,
        ST_WR_CTRL = 3'd3,
        ST_RUN     = 3'd4,
        ST_ACK     = 3'd5,
        ST_SETTLE  = 3'd6,
        ST_WR_STOP = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        w_cs_nxt;
    logic [2:0]  w_addr_nxt;
    logic [15:0] w_wdata_nxt;
    logic        w_run_nxt;

    logic        r_cs;
    logic [2:0]  r_addr;
    logic [15:0] r_wdata;
    logic        r_running;
    logic [15:0] r_tick_count;

    // The tick is consumed while in SETTLE; the timer IRQ has been cleared
    // by the preceding ACK write, so each timeout yields exactly one tick.
    logic        w_tick;
    assign w_tick = (r_state == ST_SETTLE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output decode. Bus outputs are decoded from the
    // next state and registered, so they line up with the state they
    // belong to while staying glitch-free.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cs_nxt    = 1'b0;
        w_addr_nxt  = 3'd0;
        w_wdata_nxt = 16'h0000;
        w_run_nxt   = 1'b0;

        case (r_state)
            ST_IDLE:    if (enable) w_state_nxt = ST_WR_PL;
            ST_WR_PL:   w_state_nxt = ST_WR_PH;
            ST_WR_PH:   w_state_nxt = ST_WR_CTRL;
            ST_WR_CTRL: w_state_nxt = ST_RUN;
            // Stopping outranks acknowledging a pending timeout.
            ST_RUN: begin
                if (!enable) begin
                    w_state_nxt = ST_WR_STOP;
                end else if (timer_irq) begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK:     w_state_nxt = ST_SETTLE;
            // IRQ may still read high here; SETTLE never re-acks.
            ST_SETTLE:  w_state_nxt = ST_RUN;
            ST_WR_STOP: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase

        case (w_state_nxt)
            ST_WR_PL: begin
                w_cs_nxt    = 1'b1;
                w_addr_nxt  = c_ADDR_PL;
                w_wdata_nxt = TICK_PERIOD[15:0];
            end
            ST_WR_PH: begin
                w_cs_nxt    = 1'b1;
                w_addr_nxt  = c_ADDR_PH;
                w_wdata_nxt = TICK_PERIOD[31:16];
            end
            ST_WR_CTRL: begin
                w_cs_nxt    = 1'b1;
                w_addr_nxt  = c_ADDR_CTRL;
                w_wdata_nxt = c_CTRL_START;
            end
            ST_RUN: begin
                w_run_nxt   = 1'b1;
            end
            ST_ACK: begin
                w_cs_nxt    = 1'b1;
                w_addr_nxt  = c_ADDR_STAT;
                w_wdata_nxt = 16'h0000;
                w_run_nxt   = 1'b1;
            end
            ST_SETTLE: begin
                w_run_nxt   = 1'b1;
            end
            ST_WR_STOP: begin
                w_cs_nxt    = 1'b1;
                w_addr_nxt  = c_ADDR_CTRL;
                w_wdata_nxt = c_CTRL_STOP;
            end
            default: begin
                w_cs_nxt    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered bus outputs and tick counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cs         <= 1'b0;
            r_addr       <= 3'd0;
            r_wdata      <= 16'h0000;
            r_running    <= 1'b0;
            r_tick_count <= 16'h0000;
        end else begin
            r_cs      <= w_cs_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_running <= w_run_nxt;
            if (w_tick) begin
                r_tick_count <= r_tick_count + 16'd1;
            end
        end
    end

    assign timer_chipselect = r_cs;
    assign timer_write_n    = ~r_cs;  // zero-wait-state slave: every select is a write
    assign timer_address    = r_addr;
    assign timer_writedata  = r_wdata;
    assign running          = r_running;
    assign tick_count       = r_tick_count;

    // ------------------------------------------------------------------
    // Event channels. A host load always wins over a coincident tick so
    // the channel restarts cleanly from the new period with no stray event.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] r_period;
        logic [CNT_W-1:0] r_remaining;
        logic             r_event;
        logic             w_host_wr;

        assign w_host_wr = ch_period_wr && (ch_sel == SEL_W'(i));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_period    <= '0;
                r_remaining <= '0;
                r_event     <= 1'b0;
            end else begin
                r_event <= 1'b0;
                if (w_host_wr) begin
                    r_period    <= ch_period_data;
                    r_remaining <= ch_period_data;
                end else if (w_tick && (r_period != '0)) begin
                    // remaining<=1 also covers a counter left at 0.
                    if (r_remaining <= CNT_W'(1)) begin
                        r_remaining <= r_period;
                        r_event     <= 1'b1;
                    end else begin
                        r_remaining <= r_remaining - CNT_W'(1);
                    end
                end
            end
        end

        assign ch_event[i] = r_event;
    end

endmodule
`default_nettype wire

// File: tb/tb_system_tick_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_system_tick_scheduler
//  Description : Directed self-checking bench for system_tick_scheduler.
//                Timer bus, tick counter and channel events are compared
//                against hand-computed values on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_system_tick_scheduler;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        ch_period_wr;
    logic [1:0]  ch_sel;
    logic [7:0]  ch_period_data;
    logic [3:0]  ch_event;
    logic [15:0] tick_count;
    logic        running;
    logic [2:0]  timer_address;
    logic        timer_chipselect;
    logic        timer_write_n;
    logic [15:0] timer_writedata;
    logic        timer_irq;

    int          n_checks;
    int          n_fail;
    logic [15:0] exp_ticks;

    logic [20:0] bus_obs;
    assign bus_obs = {timer_chipselect, timer_write_n, timer_address, timer_writedata};

    system_tick_scheduler #(
        .NUM_CH      (4),
        .CNT_W       (8),
        .TICK_PERIOD (32'h0002_1B0F)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .ch_period_wr     (ch_period_wr),
        .ch_sel           (ch_sel),
        .ch_period_data   (ch_period_data),
        .ch_event         (ch_event),
        .tick_count       (tick_count),
        .running          (running),
        .timer_address    (timer_address),
        .timer_chipselect (timer_chipselect),
        .timer_write_n    (timer_write_n),
        .timer_writedata  (timer_writedata),
        .timer_irq        (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected bus word: {chipselect, write_n, address, writedata}
    function automatic logic [20:0] mk_bus(input logic cs, input logic [2:0] a,
                                           input logic [15:0] d);
        return {cs, ~cs, a, d};
    endfunction

    task automatic check_value(input string tag, input logic [31:0] act,
                               input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called at a falling edge; returns at a falling edge.
    task automatic host_write(input logic [1:0] sel, input logic [7:0] data);
        ch_period_wr   = 1'b1;
        ch_sel         = sel;
        ch_period_data = data;
        @(negedge clk);
        ch_period_wr   = 1'b0;
    endtask

    // One timer timeout: RUN -> ACK -> SETTLE -> RUN. Optional host write
    // lands in the SETTLE cycle. Returns at the falling edge of the RUN
    // cycle where the tick's channel events are visible.
    task automatic do_tick(input logic hw, input logic [1:0] hsel, input logic [7:0] hdata);
        timer_irq = 1'b1;
        @(negedge clk);
        check_value("ack_bus", 32'(bus_obs), 32'(mk_bus(1'b1, 3'd0, 16'h0000)));
        check_value("ev_pulse", 32'(ch_event), 32'd0);
        @(negedge clk);
        check_value("settle_bus", 32'(bus_obs), 32'(mk_bus(1'b0, 3'd0, 16'h0000)));
        timer_irq      = 1'b0;
        ch_period_wr   = hw;
        ch_sel         = hsel;
        ch_period_data = hdata;
        @(negedge clk);
        ch_period_wr   = 1'b0;
        exp_ticks      = exp_ticks + 16'd1;
        check_value("tick_cnt", 32'(tick_count), 32'(exp_ticks));
        check_value("run_after_tick", 32'(running), 32'd1);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        exp_ticks      = 16'h0000;
        reset          = 1'b1;
        enable         = 1'b0;
        ch_period_wr   = 1'b0;
        ch_sel         = 2'd0;
        ch_period_data = 8'd0;
        timer_irq      = 1'b0;

        repeat (3) @(negedge clk);
        check_value("rst_bus",     32'(bus_obs),    32'(mk_bus(1'b0, 3'd0, 16'h0000)));
        check_value("rst_running", 32'(running),    32'd0);
        check_value("rst_tick",    32'(tick_count), 32'd0);
        check_value("rst_event",   32'(ch_event),   32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_value("idle_bus", 32'(bus_obs), 32'(mk_bus(1'b0, 3'd0, 16'h0000)));

        // Configuration sequence
        enable = 1'b1;
        @(negedge clk);
        check_value("cfg_pl", 32'(bus_obs), 32'(mk_bus(1'b1, 3'd2, 16'h1B0F)));
        check_value("cfg_pl_running", 32'(running), 32'd0);
        @(negedge clk);
        check_value("cfg_ph", 32'(bus_obs), 32'(mk_bus(1'b1, 3'd3, 16'h0002)));
        @(negedge clk);
        check_value("cfg_ctrl", 32'(bus_obs), 32'(mk_bus(1'b1, 3'd1, 16'h0007)));
        @(negedge clk);
        check_value("run_bus", 32'(bus_obs), 32'(mk_bus(1'b0, 3'd0, 16'h0000)));
        check_value("run_running", 32'(running), 32'd1);

        // First tick: acknowledged, count 0 -> 1
        check_value("tick_before", 32'(tick_count), 32'd0);
        do_tick(1'b0, 2'd0, 8'd0);

        // ch0 period 3, ch1 period 1
        host_write(2'd0, 8'd3);
        host_write(2'd1, 8'd1);
        for (int k = 1; k <= 6; k++) begin
            do_tick(1'b0, 2'd0, 8'd0);
            check_value("ev_ch01", 32'(ch_event),
                        ((k % 3) == 0) ? 32'h3 : 32'h2);
        end

        // ch2 period 1, then a coincident host load of 2 during SETTLE
        host_write(2'd2, 8'd1);
        do_tick(1'b0, 2'd0, 8'd0);
        check_value("ev_t7", 32'(ch_event), 32'h6);
        do_tick(1'b1, 2'd2, 8'd2);
        check_value("ev_t8_hostwin", 32'(ch_event), 32'h2);
        do_tick(1'b0, 2'd0, 8'd0);
        check_value("ev_t9", 32'(ch_event), 32'h3);
        do_tick(1'b0, 2'd0, 8'd0);
        check_value("ev_t10", 32'(ch_event), 32'h6);

        // Period 0 disables ch1
        host_write(2'd1, 8'd0);
        do_tick(1'b0, 2'd0, 8'd0);
        check_value("ev_t11", 32'(ch_event), 32'h0);
        do_tick(1'b0, 2'd0, 8'd0);
        check_value("ev_t12", 32'(ch_event), 32'h5);

        // Stop outranks a pending IRQ
        enable    = 1'b0;
        timer_irq = 1'b1;
        @(negedge clk);
        check_value("stop_bus", 32'(bus_obs), 32'(mk_bus(1'b1, 3'd1, 16'h0008)));
        check_value("stop_running", 32'(running), 32'd0);
        @(negedge clk);
        check_value("stopped_bus", 32'(bus_obs), 32'(mk_bus(1'b0, 3'd0, 16'h0000)));
        check_value("stopped_running", 32'(running), 32'd0);
        @(negedge clk);
        check_value("idle_irq_ignored", 32'(bus_obs), 32'(mk_bus(1'b0, 3'd0, 16'h0000)));
        check_value("stopped_tick", 32'(tick_count), 32'(exp_ticks));
        timer_irq = 1'b0;

        // Disable during configuration: sequence completes, one RUN, then stop
        enable = 1'b1;
        @(negedge clk);
        check_value("mid_pl", 32'(bus_obs), 32'(mk_bus(1'b1, 3'd2, 16'h1B0F)));
        enable = 1'b0;
        @(negedge clk);
        check_value("mid_ph", 32'(bus_obs), 32'(mk_bus(1'b1, 3'd3, 16'h0002)));
        @(negedge clk);
        check_value("mid_ctrl", 32'(bus_obs), 32'(mk_bus(1'b1, 3'd1, 16'h0007)));
        @(negedge clk);
        check_value("mid_run", 32'(running), 32'd1);
        @(negedge clk);
        check_value("mid_stop", 32'(bus_obs), 32'(mk_bus(1'b1, 3'd1, 16'h0008)));
        @(negedge clk);
        check_value("mid_idle", 32'(running), 32'd0);

        // Tick counter wrap: preset to 16'hFFFF, one more tick gives 0
        enable = 1'b1;
        repeat (4) @(negedge clk);
        check_value("rerun_running", 32'(running), 32'd1);
        force dut.r_tick_count = 16'hFFFF;
        #1;
        release dut.r_tick_count;
        exp_ticks = 16'hFFFF;
        @(negedge clk);
        do_tick(1'b0, 2'd0, 8'd0);
        check_value("wrap_zero", 32'(tick_count), 32'd0);

        // Reset asserted during ACK
        timer_irq = 1'b1;
        @(negedge clk);
        check_value("pre_rst_ack", 32'(bus_obs), 32'(mk_bus(1'b1, 3'd0, 16'h0000)));
        reset = 1'b1;
        #1;
        check_value("midrst_bus",     32'(bus_obs),    32'(mk_bus(1'b0, 3'd0, 16'h0000)));
        check_value("midrst_running", 32'(running),    32'd0);
        check_value("midrst_tick",    32'(tick_count), 32'd0);
        check_value("midrst_event",   32'(ch_event),   32'd0);
        timer_irq = 1'b0;
        @(negedge clk);
        reset     = 1'b0;
        exp_ticks = 16'h0000;
        @(negedge clk);
        check_value("reinit_pl", 32'(bus_obs), 32'(mk_bus(1'b1, 3'd2, 16'h1B0F)));
        repeat (3) @(negedge clk);
        check_value("reinit_running", 32'(running), 32'd1);
        do_tick(1'b0, 2'd0, 8'd0);
        check_value("reinit_no_ev", 32'(ch_event), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
